uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter N_REQ, default 4: number of requesters; ID_W = clog2(N_REQ), minimum 1.
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-low.
REQ-005 Port req_valid  input  N_REQ: bit i high means requester i has a word pending.
REQ-006 Port req_data  input  N_REQ*WIDTH: requester i word at bits [i*WIDTH +: WIDTH].
REQ-007 Port req_ready  output  N_REQ: one-hot, one-cycle accept pulse to the granted requester.
REQ-008 Port Data_In  output  WIDTH: latched word driven to the UART transmit input.
REQ-009 Port In_rdy  output  1: one-cycle load strobe to the UART.
REQ-010 Port Tx_Busy  input  1: UART transmitter busy flag.
REQ-011 Port Overflow  input  1: UART transmit overflow flag.
REQ-012 Port grant_id  output  ID_W: index of the last granted requester.
REQ-013 Port busy  output  1: high whenever state is not IDLE.
REQ-014 Port timeout  output  1: one-cycle pulse when the UART fails to go busy.
REQ-015 Port ovf_cnt  output  8: saturating count of cycles with Overflow high.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT_BUSY and WAIT_DONE; all outputs SHALL be registered.
REQ-017 In IDLE with any req_valid bit high at an edge, the FSM SHALL pick a winner by round-robin, starting at ptr+1 mod N_REQ and searching upward with wrap-around.
REQ-018 On the grant edge: latch req_data[winner] into Data_In; set grant_id and ptr to the winner; go to LOAD.
REQ-019 In LOAD, req_ready[winner] and In_rdy SHALL both be high for exactly one cycle; latency from sampled req_valid to req_ready SHALL be 1 cycle.
REQ-020 LOAD SHALL always go to WAIT_BUSY after one cycle, and the timeout counter (4 bits) SHALL clear.
REQ-021 In WAIT_BUSY, Tx_Busy=1 SHALL move the FSM to WAIT_DONE; otherwise the counter increments.
REQ-022 When the counter equals 15 in WAIT_BUSY with Tx_Busy=0, the FSM SHALL pulse timeout for one cycle and go to IDLE.
REQ-023 In WAIT_DONE, Tx_Busy=0 SHALL move the FSM to IDLE; there is no timeout in WAIT_DONE.
REQ-024 Request changes outside IDLE SHALL be ignored; a requester deasserting before grant is not served; the next arbitration SHALL be no earlier than the cycle after returning to IDLE.
REQ-025 Data_In SHALL hold its latched value until the next grant.
REQ-026 ovf_cnt SHALL increment each cycle Overflow=1 in any state, hold at 255, and never wrap.
REQ-027 With all req_valid high continuously, grants SHALL rotate 0,1,2,3,0,...
REQ-028 With no request pending, the FSM SHALL stay in IDLE with In_rdy=0.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE; ptr=N_REQ-1; grant_id=0; Data_In=0; req_ready=0; In_rdy=0; busy=0; timeout=0; ovf_cnt=0; counter=0.
REQ-030 Reset asserted mid-transfer SHALL abort with no further In_rdy or req_ready pulse; the first grant after release SHALL go to the lowest-index valid requester.

Verification
REQ-031 After reset, req_valid=4'b0100 with req_data[23:16]=8'hA5 -> next cycle req_ready=4'b0100, In_rdy=1, Data_In=8'hA5, grant_id=2.
REQ-032 req_valid=4'b1111 held, Tx_Busy modelled high 3 cycles after each In_rdy pulse and low 10 cycles later -> grant_id sequence 0,1,2,3,0; exactly one In_rdy per grant.
REQ-033 Single request, Tx_Busy held 0 -> timeout pulses exactly 16 cycles after the WAIT_BUSY entry edge; FSM returns to IDLE; busy=0.
REQ-034 Overflow held high 300 cycles -> ovf_cnt reaches 255 and stays at 255.
REQ-035 rst low during WAIT_DONE, then released with req_valid=4'b1010 -> all outputs at reset values while low; first grant goes to requester 1.
REQ-036 req_valid=4'b0001 asserted during WAIT_DONE of a grant to requester 3 -> no req_ready pulse before Tx_Busy falls; requester 0 is granted in the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds words from N_REQ requesters into a single
// UART transmitter. One word is handed over per grant. The arbiter then waits
// for the UART to report busy, and then for it to go idle again, before it
// arbitrates again. If the UART never starts, a short watchdog abandons the
// transfer and pulses timeout.
module uart_tx_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int N_REQ = 4,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       Data_In,
  output logic                   In_rdy,
  input  logic                   Tx_Busy,
  input  logic                   Overflow,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic                   timeout,
  output logic [7:0]             ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [ID_W-1:0]  grant_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [N_REQ-1:0] ready_nxt;
  logic             in_rdy_nxt;
  logic             timeout_nxt;
  logic             busy_nxt;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  idx;
  logic [WIDTH-1:0] words [N_REQ];

  // Split the flat request bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search: first valid requester at or after ptr+1, with wrap-around.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state and next-output logic. All outputs are registered from these values.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    grant_nxt   = grant_id;
    data_nxt    = Data_In;
    ready_nxt   = '0;
    in_rdy_nxt  = 1'b0;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          data_nxt          = words[winner];
          grant_nxt         = winner;
          ptr_nxt           = winner;
          ready_nxt[winner] = 1'b1;
          in_rdy_nxt        = 1'b1;
          state_nxt         = LOAD;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (Tx_Busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == 4'd15) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!Tx_Busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge, whatever order the statements appear in.
    if (!rst) begin
      state     <= IDLE;
      ptr       <= ID_W'(N_REQ - 1);
      cnt       <= '0;
      grant_id  <= '0;
      Data_In   <= '0;
      req_ready <= '0;
      In_rdy    <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      grant_id  <= grant_nxt;
      Data_In   <= data_nxt;
      req_ready <= ready_nxt;
      In_rdy    <= in_rdy_nxt;
      timeout   <= timeout_nxt;
      busy      <= busy_nxt;
    end
  end

  // Saturating count of cycles where the UART reports overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (Overflow && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. The tests push expected grants
// (requester id and word) into a scoreboard queue. The per-cycle tick task
// pops one entry on each In_rdy pulse and compares it. A small UART model
// drives Tx_Busy when enabled.
module tb_uart_tx_arbiter;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       Data_In;
  logic                   In_rdy;
  logic                   Tx_Busy = 1'b0;
  logic                   Overflow = 1'b0;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic                   timeout;
  logic [7:0]             ovf_cnt;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   loads = 0;
  bit   prev_in_rdy = 1'b0;
  bit   uart_en = 1'b0;
  int   uart_delay = 0;
  int   uart_hold = 0;

  uart_tx_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .Data_In   (Data_In),
    .In_rdy    (In_rdy),
    .Tx_Busy   (Tx_Busy),
    .Overflow  (Overflow),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  // Advance one cycle, sample on the falling edge, score loads, run the UART model.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    checks++;
    if (In_rdy !== 1'b1 && req_ready !== '0) begin
      errors++;
      $display("FAIL ready_without_load req_ready=%b required=%b", req_ready, {N_REQ{1'b0}});
    end
    if (In_rdy === 1'b1) begin
      loads++;
      checks++;
      if (prev_in_rdy) begin
        errors++;
        $display("FAIL in_rdy_width In_rdy high 2 cycles, required 1");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load grant_id=%0d Data_In=%h, required no load", grant_id, Data_In);
      end else begin
        e = exp_q.pop_front();
        checks += 3;
        if (grant_id !== e.id) begin
          errors++;
          $display("FAIL sb_grant_id got=%0d exp=%0d", grant_id, e.id);
        end
        if (Data_In !== e.data) begin
          errors++;
          $display("FAIL sb_data_in got=%h exp=%h", Data_In, e.data);
        end
        if (req_ready !== (N_REQ'(1) << e.id)) begin
          errors++;
          $display("FAIL sb_req_ready got=%b exp=%b", req_ready, N_REQ'(1) << e.id);
        end
      end
      if (uart_en) uart_delay = 3;
    end
    prev_in_rdy = (In_rdy === 1'b1);
    if (uart_en) begin
      if (uart_delay > 0) begin
        uart_delay--;
        if (uart_delay == 0) begin
          Tx_Busy   = 1'b1;
          uart_hold = 10;
        end
      end else if (uart_hold > 0) begin
        uart_hold--;
        if (uart_hold == 0) Tx_Busy = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    Tx_Busy = 1'b0;
    Overflow = 1'b0;
    uart_en = 1'b0;
    uart_delay = 0;
    uart_hold = 0;
    prev_in_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    req_data[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic push_exp(input int id, input logic [WIDTH-1:0] w);
    exp_t e;
    e.id = ID_W'(id);
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy=%b still set after %0d cycles, required 0", tag, busy, budget);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({Data_In, grant_id, req_ready, In_rdy, busy, timeout, ovf_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values Data_In=%h grant_id=%0d req_ready=%b In_rdy=%b busy=%b timeout=%b ovf_cnt=%0d, required all 0",
               Data_In, grant_id, req_ready, In_rdy, busy, timeout, ovf_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (In_rdy !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_request In_rdy=%b busy=%b, required 0 0", In_rdy, busy);
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_word(2, 8'hA5);
    req_valid = 4'b0100;
    push_exp(2, 8'hA5);
    uart_en = 1'b1;
    tick();
    checks++;
    if (In_rdy !== 1'b1 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_latency In_rdy=%b req_ready=%b, required 1 0100", In_rdy, req_ready);
    end
    req_valid = '0;
    set_word(2, 8'h00);
    wait_idle("single", 40);
    checks++;
    if (Data_In !== 8'hA5 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_hold Data_In=%h grant_id=%0d, required a5 2", Data_In, grant_id);
    end
  endtask

  task automatic test_round_robin();
    int start;
    int n = 0;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) set_word(i, WIDTH'(8'h50 + i));
    for (int g = 0; g < 5; g++) push_exp(g % N_REQ, WIDTH'(8'h50 + (g % N_REQ)));
    req_valid = 4'b1111;
    uart_en = 1'b1;
    start = loads;
    while (loads - start < 5 && n < 400) begin
      tick();
      n++;
    end
    req_valid = '0;
    checks++;
    if (loads - start != 5) begin
      errors++;
      $display("FAIL rr_load_count got=%0d required=5", loads - start);
    end
    wait_idle("rr", 40);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_pending %0d expected grants not seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int first = 0;
    int pulses = 0;
    apply_reset();
    uart_en = 1'b0;
    set_word(0, 8'h3C);
    req_valid = 4'b0001;
    push_exp(0, 8'h3C);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL to_busy busy=%b in WAIT_BUSY, required 1", busy);
        end
      end
      if (timeout === 1'b1) begin
        if (first == 0) first = k;
        pulses++;
      end
    end
    checks++;
    if (first != 17 || pulses != 1) begin
      errors++;
      $display("FAIL to_pulse first=%0d pulses=%0d, required 17 1", first, pulses);
    end
    checks++;
    if (busy !== 1'b0 || Data_In !== 8'h3C) begin
      errors++;
      $display("FAIL to_return busy=%b Data_In=%h, required 0 3c", busy, Data_In);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    Overflow = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 100 || k == 254 || k == 255 || k == 300) begin
        checks++;
        if (ovf_cnt !== 8'((k > 255) ? 255 : k)) begin
          errors++;
          $display("FAIL ovf_cnt_%0d got=%0d required=%0d", k, ovf_cnt, (k > 255) ? 255 : k);
        end
      end
    end
    Overflow = 1'b0;
    tick();
    checks++;
    if (ovf_cnt !== 8'd255) begin
      errors++;
      $display("FAIL ovf_hold got=%0d required=255", ovf_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    apply_reset();
    set_word(3, 8'hC3);
    set_word(1, 8'h1E);
    req_valid = 4'b1000;
    push_exp(3, 8'hC3);
    uart_en = 1'b1;
    while (Tx_Busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    uart_en = 1'b0;
    uart_delay = 0;
    uart_hold = 0;
    Tx_Busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) #1;
      else tick();
      checks++;
      if ({Data_In, grant_id, req_ready, In_rdy, busy, timeout, ovf_cnt} !== '0) begin
        errors++;
        $display("FAIL midreset_values Data_In=%h grant_id=%0d req_ready=%b In_rdy=%b busy=%b, required all 0",
                 Data_In, grant_id, req_ready, In_rdy, busy);
      end
    end
    push_exp(1, 8'h1E);
    uart_en = 1'b1;
    rst = 1'b1;
    tick();
    checks++;
    if (In_rdy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL midreset_first_grant In_rdy=%b grant_id=%0d, required 1 1", In_rdy, grant_id);
    end
    req_valid = '0;
    wait_idle("midreset", 40);
  endtask

  task automatic test_hold_off();
    apply_reset();
    set_word(3, 8'h77);
    set_word(0, 8'h0F);
    req_valid = 4'b1000;
    push_exp(3, 8'h77);
    tick();
    req_valid = '0;
    tick();
    tick();
    Tx_Busy = 1'b1;
    tick();
    tick();
    req_valid = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (In_rdy !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL holdoff_ignored In_rdy=%b req_ready=%b, required 0 0000", In_rdy, req_ready);
      end
    end
    push_exp(0, 8'h0F);
    Tx_Busy = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || In_rdy !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_idle busy=%b In_rdy=%b, required 0 0", busy, In_rdy);
    end
    tick();
    checks++;
    if (In_rdy !== 1'b1 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL holdoff_grant In_rdy=%b req_ready=%b, required 1 0001", In_rdy, req_ready);
    end
    req_valid = '0;
    tick();
    tick();
    Tx_Busy = 1'b1;
    tick();
    Tx_Busy = 1'b0;
    wait_idle("holdoff", 10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_hold_off();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain %0d expected loads never seen, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
